// File: rtl/pipe_field_controller.sv
// Pipe ring scroller: init layout, tick-driven X scroll, recycle behind rearmost pipe, random gap Y fill, scoring.
// All outputs registered (1-cycle); oRandReq holds while any pipe lacks a Y, one Y captured per req&valid cycle.
module pipe_field_controller #(
   parameter int NUM_PIPES = 3,
   parameter int COORD_W   = 12,
   parameter int SCREEN_W  = 640,
   parameter int PIPE_W    = 52,
   parameter int PIPE_DIST = 275,
   parameter int Y_MIN     = 80,
   parameter int Y_RANGE   = 200,
   parameter int BIRD_X    = 100,
   parameter int TICK_DIV  = 50000,
   parameter int SCORE_W   = 16,
   parameter int RAND_W    = 32
) (
   input  logic                           iClock,
   input  logic                           iResetN,
   input  logic [1:0]                     iState,
   input  logic [3:0]                     iSpeed,
   input  logic [RAND_W-1:0]              iRandom,
   input  logic                           iRandValid,
   output logic                           oRandReq,
   output logic [NUM_PIPES*COORD_W-1:0]   oPipeX,
   output logic [NUM_PIPES*COORD_W-1:0]   oPipeY,
   output logic [NUM_PIPES-1:0]           oPipeValid,
   output logic [SCORE_W-1:0]             oScore,
   output logic                           oScorePulse
);
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int CNT_W  = $clog2(NUM_PIPES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_t;
   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [COORD_W:0]   wide_t;

   state_t               state_q, state_d;
   coord_t               x_q [NUM_PIPES];
   coord_t               x_d [NUM_PIPES];
   coord_t               y_q [NUM_PIPES];
   coord_t               y_d [NUM_PIPES];
   logic [NUM_PIPES-1:0] vld_q, vld_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 pulse_q, pulse_d;
   logic [TICK_W-1:0]    tick_q, tick_d;

   coord_t               spd, rand_y;
   logic [RAND_W-1:0]    rand_mod;
   logic [CNT_W-1:0]     cross_cnt;
   logic [SCORE_W:0]     score_sum;
   logic                 hs_done, rec_done;

   function automatic coord_t init_x(input int i);
      return coord_t'(SCREEN_W + i * PIPE_DIST);
   endfunction

   assign oRandReq = (state_q == S_RUN) && !(&vld_q);

   always_ff @(posedge iClock) begin
      if (!iResetN) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= init_x(i);
            y_q[i] <= '1;
         end
         vld_q   <= '0;
         score_q <= '0;
         pulse_q <= 1'b0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vld_q   <= vld_d;
         score_q <= score_d;
         pulse_q <= pulse_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      vld_d     = vld_q;
      score_d   = score_q;
      pulse_d   = 1'b0;
      tick_d    = tick_q;
      spd       = coord_t'(iSpeed);
      rand_mod  = iRandom % RAND_W'(Y_RANGE);
      rand_y    = coord_t'(Y_MIN) + coord_t'(rand_mod);
      cross_cnt = '0;
      score_sum = '0;
      hs_done   = 1'b0;
      rec_done  = 1'b0;

      case (state_q)
         S_IDLE:  if (iState == 2'd1) state_d = S_RUN;
         S_RUN:   if (iState == 2'd2) state_d = S_PAUSE;
                  else if (iState == 2'd3) state_d = S_OVER;
         S_PAUSE: if (iState == 2'd1) state_d = S_RUN;
                  else if (iState == 2'd3) state_d = S_OVER;
         default: ;
      endcase

      if (iState == 2'd0) begin
         state_d = S_IDLE;
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i] = init_x(i);
            y_d[i] = '1;
         end
         vld_d   = '0;
         score_d = '0;
         tick_d  = '0;
      end else if (state_q == S_RUN) begin
         if (iRandValid) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
               if (!hs_done && !vld_q[i]) begin
                  y_d[i]   = rand_y;
                  vld_d[i] = 1'b1;
                  hs_done  = 1'b1;
               end
            end
         end
         if (tick_q == TICK_W'(TICK_DIV - 1)) begin
            tick_d = '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
               x_d[i] = x_q[i] - spd;
               if (vld_q[i] && (wide_t'(x_q[i]) + wide_t'(PIPE_W) >= wide_t'(BIRD_X))
                            && (wide_t'(x_d[i]) + wide_t'(PIPE_W) <  wide_t'(BIRD_X)))
                  cross_cnt = cross_cnt + 1'b1;
            end
            if (cross_cnt != '0) begin
               pulse_d   = 1'b1;
               score_sum = {1'b0, score_q} + (SCORE_W + 1)'(cross_cnt);
               score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            end
         end else begin
            tick_d = tick_q + 1'b1;
            // Recycled pipe lands one spacing behind its ring predecessor, which is the rearmost pipe.
            for (int i = 0; i < NUM_PIPES; i++) begin
               if (!rec_done && (wide_t'(x_q[i]) < -wide_t'(PIPE_W))) begin
                  x_d[i]   = x_q[(i == 0) ? NUM_PIPES - 1 : i - 1] + coord_t'(PIPE_DIST);
                  y_d[i]   = '1;
                  vld_d[i] = 1'b0;
                  rec_done = 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
      assign oPipeX[g*COORD_W +: COORD_W] = x_q[g];
      assign oPipeY[g*COORD_W +: COORD_W] = y_q[g];
   end
   assign oPipeValid  = vld_q;
   assign oScore      = score_q;
   assign oScorePulse = pulse_q;

endmodule

// File: tb/tb_pipe_field_controller.sv
// Directed bench for pipe_field_controller (3 pipes, 4-clock tick); second instance with 4-bit score for saturation.
module tb_pipe_field_controller;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  st;
   logic [3:0]  speed;
   logic [31:0] rnd;
   logic        rnd_vld;

   logic        req, pulse, req_s, pulse_s;
   logic [35:0] px_o, py_o, px_s, py_s;
   logic [2:0]  pv, pv_s;
   logic [15:0] score;
   logic [3:0]  score_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_field_controller #(.NUM_PIPES(3), .TICK_DIV(4)) dut (
      .iClock(clk), .iResetN(rst_n), .iState(st), .iSpeed(speed), .iRandom(rnd),
      .iRandValid(rnd_vld), .oRandReq(req), .oPipeX(px_o), .oPipeY(py_o),
      .oPipeValid(pv), .oScore(score), .oScorePulse(pulse));

   pipe_field_controller #(.NUM_PIPES(3), .TICK_DIV(4), .SCORE_W(4)) dut_s (
      .iClock(clk), .iResetN(rst_n), .iState(st), .iSpeed(speed), .iRandom(rnd),
      .iRandValid(rnd_vld), .oRandReq(req_s), .oPipeX(px_s), .oPipeY(py_s),
      .oPipeValid(pv_s), .oScore(score_s), .oScorePulse(pulse_s));

   function automatic int xp(input int i);
      logic signed [11:0] v;
      v = px_o[i*12 +: 12];
      return int'(v);
   endfunction

   function automatic int yp(input int i);
      logic signed [11:0] v;
      v = py_o[i*12 +: 12];
      return int'(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_run();
      st = 2'd0;
      step();
      st = 2'd1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; st = 2'd0; speed = 4'd0; rnd = '0; rnd_vld = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (xp(i) !== 640 + 275 * i) begin
            errors++; $display("FAIL reset_x%0d got %0d exp %0d", i, xp(i), 640 + 275 * i);
         end
         checks++;
         if (yp(i) !== -1) begin
            errors++; $display("FAIL reset_y%0d got %0d exp -1", i, yp(i));
         end
      end
      checks++;
      if (pv !== 3'b000 || score !== 16'd0 || req !== 1'b0 || pulse !== 1'b0) begin
         errors++; $display("FAIL reset_flags got v=%b s=%0d req=%b p=%b exp 000/0/0/0", pv, score, req, pulse);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      st = 2'd1; speed = 4'd0; rnd_vld = 1'b0;
      step();
      repeat (2) step();
      checks++;
      if (req !== 1'b1 || pv !== 3'b000) begin
         errors++; $display("FAIL fill_stall got req=%b v=%b exp 1/000", req, pv);
      end
      rnd_vld = 1'b1; rnd = 32'd250;
      step();
      checks++;
      if (yp(0) !== 130 || pv !== 3'b001) begin
         errors++; $display("FAIL fill_y0 got y=%0d v=%b exp 130/001", yp(0), pv);
      end
      rnd = 32'hFFFF_FFFF;
      step();
      checks++;
      if (yp(1) !== 175 || pv !== 3'b011) begin
         errors++; $display("FAIL fill_y1 got y=%0d v=%b exp 175/011", yp(1), pv);
      end
      rnd = 32'd199;
      step();
      checks++;
      if (yp(2) !== 279 || pv !== 3'b111 || req !== 1'b0 || yp(0) !== 130) begin
         errors++; $display("FAIL fill_y2 got y2=%0d y0=%0d v=%b req=%b exp 279/130/111/0", yp(2), yp(0), pv, req);
      end
      rnd_vld = 1'b0;
   endtask

   task automatic test_pause();
      rnd_vld = 1'b1; rnd = 32'd0; speed = 4'd2;
      go_run();
      repeat (3) step();
      checks++;
      if (xp(0) !== 640) begin
         errors++; $display("FAIL scroll_pre got %0d exp 640", xp(0));
      end
      step();
      checks++;
      if (xp(0) !== 638 || xp(2) !== 1188) begin
         errors++; $display("FAIL scroll_tick got x0=%0d x2=%0d exp 638/1188", xp(0), xp(2));
      end
      repeat (2) step();
      st = 2'd2;
      step();
      repeat (10) step();
      checks++;
      if (xp(0) !== 638 || xp(1) !== 913 || req !== 1'b0 || pulse !== 1'b0) begin
         errors++; $display("FAIL pause_hold got x0=%0d x1=%0d req=%b exp 638/913/0", xp(0), xp(1), req);
      end
      st = 2'd1;
      step();
      checks++;
      if (xp(0) !== 638) begin
         errors++; $display("FAIL resume_first got %0d exp 638", xp(0));
      end
      step();
      checks++;
      if (xp(0) !== 636) begin
         errors++; $display("FAIL resume_phase got %0d exp 636", xp(0));
      end
   endtask

   task automatic test_recycle();
      rnd_vld = 1'b1; rnd = 32'd10; speed = 4'd9;
      go_run();
      repeat (308) step();
      checks++;
      if (xp(0) !== -53 || xp(2) !== 497 || score !== 16'd1) begin
         errors++; $display("FAIL recycle_pre got x0=%0d x2=%0d s=%0d exp -53/497/1", xp(0), xp(2), score);
      end
      rnd_vld = 1'b0;
      step();
      checks++;
      if (xp(0) !== 772 || yp(0) !== -1 || pv[0] !== 1'b0 || req !== 1'b1 || xp(1) !== 222) begin
         errors++; $display("FAIL recycle got x0=%0d y0=%0d v0=%b req=%b x1=%0d exp 772/-1/0/1/222",
                            xp(0), yp(0), pv[0], req, xp(1));
      end
      st = 2'd2;
      step();
      checks++;
      if (req !== 1'b0 || pv[0] !== 1'b0) begin
         errors++; $display("FAIL pause_req got req=%b v0=%b exp 0/0", req, pv[0]);
      end
   endtask

   task automatic test_score();
      rnd_vld = 1'b1; rnd = 32'd5; speed = 4'd1;
      go_run();
      repeat (592 * 4) step();
      checks++;
      if (xp(0) !== 48 || xp(1) !== 323 || score !== 16'd0) begin
         errors++; $display("FAIL score_pre got x0=%0d x1=%0d s=%0d exp 48/323/0", xp(0), xp(1), score);
      end
      repeat (3) step();
      checks++;
      if (xp(0) !== 48 || score !== 16'd0 || pulse !== 1'b0) begin
         errors++; $display("FAIL score_edge got x0=%0d s=%0d p=%b exp 48/0/0", xp(0), score, pulse);
      end
      step();
      checks++;
      if (xp(0) !== 47 || score !== 16'd1 || pulse !== 1'b1 || score_s !== 4'd1) begin
         errors++; $display("FAIL score_cross got x0=%0d s=%0d p=%b ss=%0d exp 47/1/1/1", xp(0), score, pulse, score_s);
      end
      step();
      checks++;
      if (pulse !== 1'b0 || score !== 16'd1) begin
         errors++; $display("FAIL score_pulse_len got p=%b s=%0d exp 0/1", pulse, score);
      end
   endtask

   task automatic test_over();
      st = 2'd3;
      step();
      repeat (20) step();
      checks++;
      if (xp(0) !== 47 || score !== 16'd1 || req !== 1'b0 || pulse !== 1'b0) begin
         errors++; $display("FAIL over_hold got x0=%0d s=%0d req=%b exp 47/1/0", xp(0), score, req);
      end
      st = 2'd1;
      step();
      checks++;
      if (xp(0) !== 47) begin
         errors++; $display("FAIL over_sticky got %0d exp 47", xp(0));
      end
      st = 2'd0;
      step();
      checks++;
      if (xp(0) !== 640 || score !== 16'd0) begin
         errors++; $display("FAIL over_exit got x0=%0d s=%0d exp 640/0", xp(0), score);
      end
   endtask

   task automatic test_reset_mid();
      rnd_vld = 1'b0; speed = 4'd3;
      go_run();
      rnd_vld = 1'b1; rnd = 32'd250; rst_n = 1'b0;
      step();
      checks++;
      if (pv !== 3'b000 || yp(0) !== -1 || xp(0) !== 640 || req !== 1'b0) begin
         errors++; $display("FAIL midreset got v=%b y0=%0d x0=%0d req=%b exp 000/-1/640/0", pv, yp(0), xp(0), req);
      end
      rst_n = 1'b1; rnd_vld = 1'b0; st = 2'd1;
      step();
      rnd_vld = 1'b1; st = 2'd0;
      step();
      checks++;
      if (pv !== 3'b000 || yp(0) !== -1 || xp(2) !== 1190 || req !== 1'b0) begin
         errors++; $display("FAIL mididle got v=%b y0=%0d x2=%0d req=%b exp 000/-1/1190/0", pv, yp(0), xp(2), req);
      end
   endtask

   task automatic test_saturate();
      int np = 0;
      int nps = 0;
      rnd_vld = 1'b1; rnd = 32'd77; speed = 4'd15;
      go_run();
      for (int c = 0; c < 330 * 4; c++) begin
         step();
         if (pulse === 1'b1) np++;
         if (pulse_s === 1'b1) nps++;
      end
      checks++;
      if (score !== 16'd16) begin
         errors++; $display("FAIL sat_wide got %0d exp 16", score);
      end
      checks++;
      if (score_s !== 4'd15) begin
         errors++; $display("FAIL sat_narrow got %0d exp 15", score_s);
      end
      checks++;
      if (np !== 16 || nps !== 16) begin
         errors++; $display("FAIL sat_pulses got %0d/%0d exp 16/16", np, nps);
      end
      st = 2'd3;
      repeat (6) step();
      checks++;
      if (score !== 16'd16 || score_s !== 4'd15) begin
         errors++; $display("FAIL sat_over got %0d/%0d exp 16/15", score, score_s);
      end
   endtask

   initial begin
      rst_n = 1'b0; st = 2'd0; speed = 4'd0; rnd = '0; rnd_vld = 1'b0;
      test_reset();
      test_fill();
      test_pause();
      test_recycle();
      test_score();
      test_over();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
